// File: rtl/anode_scan_pkg.sv
// anode_scan_pkg
//   Shared types and defaults for the anode scan controller.
//   - scan_state_t : controller state encoding (IDLE, SCAN, BLANK)
//   - DEF_*        : default parameter values
//   - clog2_f      : ceiling log2, used to size the channel index
package anode_scan_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SCAN  = 2'd1,
      BLANK = 2'd2
   } scan_state_t;

   localparam int DEF_N_CH      = 4;
   localparam int DEF_DIV_W     = 16;
   localparam int DEF_BLANK_CYC = 2;

   // Ceiling log2 with a floor of 1 bit so a 1-channel index still has width.
   function automatic int clog2_f(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++)
         if ((1 << i) < v) r = i + 1;
      return (r < 1) ? 1 : r;
   endfunction

endpackage

// File: rtl/scan_dwell_counter.sv
// scan_dwell_counter
//   Loadable down-counter that stops at zero.
//   Ports:
//     clk, rst  : clock, synchronous active-high reset (count -> 0)
//     load      : load load_val (wins over hold)
//     hold      : freeze the count
//     load_val  : reload value
//     zero      : count is zero
module scan_dwell_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic         hold,
   input  logic [W-1:0] load_val,
   output logic         zero
);

   logic [W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst)
         cnt <= '0;
      else if (load)
         cnt <= load_val;
      else if (!hold && (cnt != '0))
         cnt <= cnt - 1'b1;
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/anode_scan_ctrl.sv
// anode_scan_ctrl
//   Scans N_CH active-low one-cold select lines in rotation, each line held
//   for DIV+1 cycles, or pins one line chosen by SEL_IN while HOLD=1.
//   Optional macro SCAN_BLANK_EN inserts a BLANK_CYC-cycle all-ones gap
//   between channels.
//   Ports:
//     CLK, RST : clock, synchronous active-high reset
//     EN       : scan enable (low -> outputs blank, back to IDLE)
//     HOLD     : 1 = pin SEL_IN, 0 = auto-rotate
//     SEL_IN   : channel pinned while HOLD=1 (out-of-range -> all ones)
//     DIV      : dwell reload value
//     OUT      : registered active-low one-cold select
//     IDX      : registered index of the driven channel
//     WRAP     : one-cycle pulse when IDX wraps N_CH-1 -> 0
module anode_scan_ctrl
   import anode_scan_pkg::*;
#(
   parameter int N_CH      = DEF_N_CH,
   parameter int IDX_W     = clog2_f(N_CH),
   parameter int DIV_W     = DEF_DIV_W,
   parameter int BLANK_CYC = DEF_BLANK_CYC
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             EN,
   input  logic             HOLD,
   input  logic [IDX_W-1:0] SEL_IN,
   input  logic [DIV_W-1:0] DIV,
   output logic [N_CH-1:0]  OUT,
   output logic [IDX_W-1:0] IDX,
   output logic             WRAP
);

   if (N_CH < 2 || BLANK_CYC < 1) begin : g_bad_param
      $error("anode_scan_ctrl: N_CH must be >= 2 and BLANK_CYC >= 1");
   end

   localparam logic [N_CH-1:0] ONE = N_CH'(1);

   scan_state_t      state, state_n;
   logic [N_CH-1:0]  out_n;
   logic [IDX_W-1:0] idx_n, idx_adv;
   logic             wrap_n, idx_last, sel_ok;
   logic             held_q, held_n;
   logic             dw_load, dw_hold, dw_zero;

   assign sel_ok   = (int'(SEL_IN) < N_CH);
   assign idx_last = (IDX == IDX_W'(N_CH - 1));
   assign idx_adv  = idx_last ? '0 : IDX + 1'b1;

   scan_dwell_counter #(.W(DIV_W)) u_dwell (
      .clk      (CLK),
      .rst      (RST),
      .load     (dw_load),
      .hold     (dw_hold),
      .load_val (DIV),
      .zero     (dw_zero)
   );

`ifdef SCAN_BLANK_EN
   localparam int BW = clog2_f(BLANK_CYC) + 1;
   logic bl_load, bl_hold, bl_zero;

   scan_dwell_counter #(.W(BW)) u_blank (
      .clk      (CLK),
      .rst      (RST),
      .load     (bl_load),
      .hold     (bl_hold),
      .load_val (BW'(BLANK_CYC - 1)),
      .zero     (bl_zero)
   );
`endif

   always_comb begin
      state_n = state;
      out_n   = '1;
      idx_n   = IDX;
      wrap_n  = 1'b0;
      held_n  = 1'b0;
      dw_load = 1'b0;
      dw_hold = 1'b1;
`ifdef SCAN_BLANK_EN
      bl_load = 1'b0;
      bl_hold = 1'b1;
`endif
      if (!EN) begin
         state_n = IDLE;
      end else begin
         case (state)
            IDLE: begin
               state_n = SCAN;
               dw_load = 1'b1;
               if (HOLD && sel_ok) begin
                  idx_n = SEL_IN;
                  out_n = ~(ONE << SEL_IN);
               end else begin
                  idx_n = '0;
                  if (!HOLD) out_n = ~ONE;
               end
            end
            SCAN: begin
               if (HOLD) begin
                  // Counter pinned at DIV; an illegal SEL_IN blanks but keeps IDX.
                  dw_load = 1'b1;
                  held_n  = 1'b1;
                  if (sel_ok) begin
                     idx_n = SEL_IN;
                     out_n = ~(ONE << SEL_IN);
                  end
               end else if (held_q) begin
                  // First cycle after HOLD drops: restart a full dwell on IDX.
                  dw_load = 1'b1;
                  out_n   = ~(ONE << IDX);
               end else if (dw_zero) begin
`ifdef SCAN_BLANK_EN
                  state_n = BLANK;
                  bl_load = 1'b1;
`else
                  idx_n   = idx_adv;
                  wrap_n  = idx_last;
                  dw_load = 1'b1;
                  out_n   = ~(ONE << idx_adv);
`endif
               end else begin
                  dw_hold = 1'b0;
                  out_n   = ~(ONE << IDX);
               end
            end
`ifdef SCAN_BLANK_EN
            BLANK: begin
               if (bl_zero) begin
                  state_n = SCAN;
                  idx_n   = idx_adv;
                  wrap_n  = idx_last;
                  dw_load = 1'b1;
                  out_n   = ~(ONE << idx_adv);
               end else begin
                  bl_hold = 1'b0;
               end
            end
`endif
            default: state_n = IDLE;
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state  <= IDLE;
         OUT    <= '1;
         IDX    <= '0;
         WRAP   <= 1'b0;
         held_q <= 1'b0;
      end else begin
         state  <= state_n;
         OUT    <= out_n;
         IDX    <= idx_n;
         WRAP   <= wrap_n;
         held_q <= held_n;
      end
   end

endmodule

// File: tb/tb_anode_scan_ctrl.sv
// tb_anode_scan_ctrl
//   Directed bench for anode_scan_ctrl: a 4-channel instance for rotation,
//   enable, hold, reset and divider cases, plus 8- and 5-channel instances
//   sharing inputs for wide and out-of-range SEL_IN hold behaviour.
module tb_anode_scan_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        en4, hold4;
   logic [1:0]  sel4;
   logic [15:0] div4;
   logic [3:0]  out4;
   logic [1:0]  idx4;
   logic        wrap4;

   logic        en8, hold8;
   logic [2:0]  sel8;
   logic [15:0] div8;
   logic [7:0]  out8;
   logic [2:0]  idx8;
   logic        wrap8;
   logic [4:0]  out5;
   logic [2:0]  idx5;
   logic        wrap5;

   int n_chk = 0;
   int n_err = 0;

   anode_scan_ctrl #(.N_CH(4)) dut4 (
      .CLK(clk), .RST(rst), .EN(en4), .HOLD(hold4), .SEL_IN(sel4), .DIV(div4),
      .OUT(out4), .IDX(idx4), .WRAP(wrap4)
   );

   anode_scan_ctrl #(.N_CH(8)) dut8 (
      .CLK(clk), .RST(rst), .EN(en8), .HOLD(hold8), .SEL_IN(sel8), .DIV(div8),
      .OUT(out8), .IDX(idx8), .WRAP(wrap8)
   );

   anode_scan_ctrl #(.N_CH(5)) dut5 (
      .CLK(clk), .RST(rst), .EN(en8), .HOLD(hold8), .SEL_IN(sel8), .DIV(div8),
      .OUT(out5), .IDX(idx5), .WRAP(wrap5)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic [3:0] rot_exp [0:16] = '{4'he, 4'he, 4'he, 4'he, 4'hd, 4'hd, 4'hd, 4'hd,
                                   4'hb, 4'hb, 4'hb, 4'hb, 4'h7, 4'h7, 4'h7, 4'h7, 4'he};
   logic [3:0] divchg_exp [0:9] = '{4'he, 4'he, 4'he, 4'hd, 4'hd,
                                    4'hb, 4'hb, 4'h7, 4'h7, 4'he};
`ifdef SCAN_BLANK_EN
   logic [3:0] blank_exp [0:16] = '{4'he, 4'he, 4'hf, 4'hf, 4'hd, 4'hd, 4'hf, 4'hf,
                                     4'hb, 4'hb, 4'hf, 4'hf, 4'h7, 4'h7, 4'hf, 4'hf, 4'he};
   localparam int BLEN = 17;
`else
   logic [3:0] blank_exp [0:8] = '{4'he, 4'he, 4'hd, 4'hd, 4'hb, 4'hb, 4'h7, 4'h7, 4'he};
   localparam int BLEN = 9;
`endif

   initial begin
      rst = 1'b1; en4 = 1'b0; hold4 = 1'b0; sel4 = '0; div4 = 16'd3;
      en8 = 1'b0; hold8 = 1'b0; sel8 = '0; div8 = 16'd2;
      tick(); tick();
      chk("rst_out", out4, 4'hf);
      chk("rst_idx", idx4, 0);
      chk("rst_wrap", wrap4, 0);
      chk("rst_out8", out8, 8'hff);
      rst = 1'b0;
      tick();
      chk("idle_out", out4, 4'hf);

      // basic rotation, DIV=3
      en4 = 1'b1;
      for (int c = 0; c < 17; c++) begin
         tick();
         chk($sformatf("rot_out[%0d]", c), out4, rot_exp[c]);
         chk($sformatf("rot_wrap[%0d]", c), wrap4, (c == 16) ? 1 : 0);
      end

      // enable drop mid-dwell on channel 2
      repeat (9) tick();
      chk("ch2_out", out4, 4'hb);
      en4 = 1'b0;
      tick();
      chk("en_off_out", out4, 4'hf);
      chk("en_off_idx", idx4, 2);
      en4 = 1'b1;
      tick();
      chk("restart_out", out4, 4'he);
      chk("restart_idx", idx4, 0);
      for (int c = 0; c < 3; c++) begin
         tick();
         chk("restart_dwell", out4, 4'he);
      end
      tick();
      chk("restart_next", out4, 4'hd);

      // hold on channel 2
      hold4 = 1'b1; sel4 = 2'd2;
      for (int c = 0; c < 7; c++) begin
         tick();
         chk("hold_out", out4, 4'hb);
         chk("hold_wrap", wrap4, 0);
      end
      hold4 = 1'b0;
      for (int c = 0; c < 4; c++) begin
         tick();
         chk("unhold_dwell", out4, 4'hb);
      end
      for (int c = 0; c < 4; c++) begin
         tick();
         chk("unhold_next", out4, 4'h7);
      end
      tick();
      chk("unhold_wrap_out", out4, 4'he);
      chk("unhold_wrap", wrap4, 1);

      // reset mid-dwell, then DIV=0
      rst = 1'b1; div4 = 16'd0;
      tick();
      chk("rst_mid_out", out4, 4'hf);
      chk("rst_mid_idx", idx4, 0);
      chk("rst_mid_wrap", wrap4, 0);
      rst = 1'b0;
      tick(); chk("div0_a", out4, 4'he);
      tick(); chk("div0_b", out4, 4'hd);
      tick(); chk("div0_c", out4, 4'hb);
      tick(); chk("div0_d", out4, 4'h7);
      tick(); chk("div0_e", out4, 4'he); chk("div0_wrap", wrap4, 1);

      // DIV 3 -> 1 mid-dwell
      en4 = 1'b0; div4 = 16'd3;
      tick();
      en4 = 1'b1;
      tick();
      chk("divchg_start", out4, 4'he);
      div4 = 16'd1;
      for (int c = 0; c < 10; c++) begin
         tick();
         chk($sformatf("divchg[%0d]", c), out4, divchg_exp[c]);
      end

      // channel pattern with DIV=1 (blank gaps when compiled in)
      en4 = 1'b0;
      tick();
      en4 = 1'b1;
      for (int c = 0; c < BLEN; c++) begin
         tick();
         chk($sformatf("blank_out[%0d]", c), out4, blank_exp[c]);
         chk($sformatf("blank_wrap[%0d]", c), wrap4, (c == BLEN - 1) ? 1 : 0);
      end
      en4 = 1'b0;

      // 8-channel hold and out-of-range SEL_IN on the 5-channel instance
      en8 = 1'b1; hold8 = 1'b1; sel8 = 3'd5; div8 = 16'd2;
      tick();
      chk("h8_out", out8, 8'hdf);
      chk("h8_idx", idx8, 5);
      chk("h5_bad_out", out5, 5'h1f);
      sel8 = 3'd3;
      tick();
      chk("h8_out3", out8, 8'hf7);
      chk("h5_out3", out5, 5'h17);
      sel8 = 3'd5;
      tick();
      chk("h8_out5", out8, 8'hdf);
      chk("h5_bad_out2", out5, 5'h1f);
      chk("h5_bad_idx", idx5, 3);
      chk("h8_wrap", wrap8, 0);
      hold8 = 1'b0;
      for (int c = 0; c < 3; c++) begin
         tick();
         chk("r8_dwell", out8, 8'hdf);
         chk("r5_dwell", out5, 5'h17);
      end
      tick();
      chk("r8_next", out8, 8'hbf);
      chk("r8_idx", idx8, 6);
      chk("r5_next", out5, 5'h0f);

      // random stimulus: never more than one low bit
      for (int c = 0; c < 300; c++) begin
         en4 = ($urandom_range(0, 9) != 0);
         hold4 = ($urandom_range(0, 3) == 0);
         sel4 = 2'($urandom_range(0, 3));
         div4 = 16'($urandom_range(0, 3));
         en8 = ($urandom_range(0, 9) != 0);
         hold8 = ($urandom_range(0, 3) == 0);
         sel8 = 3'($urandom_range(0, 7));
         div8 = 16'($urandom_range(0, 3));
         tick();
         chk("inv4", ($countones(~out4) <= 1) ? 1 : 0, 1);
         chk("inv8", ($countones(~out8) <= 1) ? 1 : 0, 1);
         chk("inv5", ($countones(~out5) <= 1) ? 1 : 0, 1);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/anode_scan_ctrl.md
# anode_scan_ctrl

Parametrised, clocked successor to the 2-to-4 active-low select decoder. It scans N_CH active-low one-cold select lines in rotation, holding each line for a programmable number of clock cycles. It also supports a hold mode that pins a single externally chosen line. It sits between the DPWM/display datapath and the physical select pins, replacing the free-standing decoder and its external counter.

## Interface
Parameters:
- N_CH, 4: number of select lines; must be ≥ 2.
- IDX_W, $clog2(N_CH): width of the channel index.
- DIV_W, 16: width of the dwell reload value.
- BLANK_CYC, 2: blank gap length in cycles, ≥ 1; only used when SCAN_BLANK_EN is defined.

Ports:
- CLK  in  1  system clock; all logic on the rising edge.
- RST  in  1  synchronous, active-high reset.
- EN  in  1  scan enable; low blanks all outputs.
- HOLD  in  1  1 = pin channel SEL_IN; 0 = auto-rotate.
- SEL_IN  in  IDX_W  channel to pin while HOLD=1.
- DIV  in  DIV_W  dwell reload; each channel is shown for DIV+1 cycles.
- OUT  out  N_CH  active-low one-cold select (registered).
- IDX  out  IDX_W  index of the channel currently driven (registered).
- WRAP  out  1  one-cycle pulse when IDX wraps from N_CH-1 to 0.

## Operation
- States: IDLE, SCAN, BLANK. BLANK is reachable only with SCAN_BLANK_EN defined.
- Reset (RST=1 at an edge) sets: state IDLE, OUT all ones, IDX=0, WRAP=0, dwell counter 0. Reset wins over all other inputs, including mid-dwell and mid-blank.
- IDLE:
  - OUT is all ones.
  - On EN=1: go to SCAN, load the counter with DIV, set IDX=0 (or SEL_IN if HOLD=1).
- SCAN:
  - OUT = ~(1 << IDX).
  - The counter decrements by 1 each cycle.
  - When counter==0 and HOLD=0: IDX advances to IDX+1, wrapping N_CH-1 → 0, and the counter reloads DIV.
  - WRAP=1 in exactly the cycle in which IDX becomes 0 through a wrap; it is never asserted on entry from IDLE.
- HOLD=1 (in SCAN):
  - IDX follows the registered SEL_IN every cycle and the counter is held at DIV.
  - If SEL_IN ≥ N_CH, OUT is all ones and IDX holds its last legal value.
  - WRAP is never asserted.
- HOLD falling: rotation resumes from the current IDX with a full DIV+1 dwell.
- EN=0 in any state: next cycle the state is IDLE and OUT is all ones. IDX is preserved but reset to 0 on the next start.
- A DIV change mid-dwell takes effect at the next reload only.
- With DIV=0, the index advances every cycle (each channel shown for 1 cycle).
- Outside reset, OUT is always either one-cold or all ones; two low bits at once is illegal.

## Timing
- Latency: OUT shows the first channel in the cycle after EN is sampled high (1 cycle); it blanks 1 cycle after EN is sampled low.
- Channel period: DIV+1 cycles, or DIV+1+BLANK_CYC with blanking compiled in.
- Frame period: N_CH × channel period.
- HOLD and SEL_IN act with 1-cycle latency.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- Macro: SCAN_BLANK_EN.
- Defined:
  - On dwell expiry with HOLD=0, enter BLANK and drive OUT all ones for BLANK_CYC cycles, with IDX unchanged.
  - On BLANK exit: IDX advances, WRAP pulses if IDX wraps, the counter reloads DIV, and the state returns to SCAN.
  - EN=0 or RST during BLANK behaves exactly as in SCAN.
- Undefined: BLANK logic is absent and channels switch back-to-back with no gap.

## Structure
- Shared package (anode_scan_pkg):
  - State enum (IDLE, SCAN, BLANK).
  - Constant default parameter values.
  - A clog2 helper for IDX_W.
- One sub-module: scan_dwell_counter.
  - Loadable down-counter of width DIV_W.
  - Inputs: load, load_val, hold.
  - Output: zero flag.
  - Reused for the BLANK_CYC countdown.

## Test plan
- Basic rotation: N_CH=4, DIV=3, EN raised after reset, HOLD=0 → OUT sequence is 1110×4, 1101×4, 1011×4, 0111×4, then 1110; WRAP=1 only on the first cycle of the returning 1110.
- Enable control: EN dropped mid-dwell on channel 2 → OUT=1111 on the next cycle; EN raised again → OUT=1110 after 1 cycle, with a full 4-cycle dwell.
- Hold mode: HOLD=1, SEL_IN=2 → OUT=1011 held indefinitely with WRAP=0. Then SEL_IN=5 with N_CH=8 → OUT=11011111. Then HOLD=0 → rotation continues from index 5 with a DIV+1 dwell.
- Reset and divider edge cases:
  - RST asserted mid-dwell → OUT=1111, IDX=0 on the next cycle.
  - DIV=0 → OUT changes every cycle: 1110, 1101, 1011, 0111.
  - DIV changed from 3 to 1 mid-dwell → current dwell still 4 cycles, later dwells 2 cycles.
- Blanking (SCAN_BLANK_EN defined, BLANK_CYC=2, DIV=1): OUT = 1110, 1110, 1111, 1111, 1101, 1101, 1111, 1111, …; WRAP coincides with IDX returning to 0 after the final blank.
- Invariant: over randomised EN/HOLD/SEL_IN/DIV stimulus, OUT never has more than one zero bit.
